seq3_cover_monitor: RTL and testbench
=====================================

Name: seq3_cover_monitor

Overview:
- Synthesizable hardware monitor that sits directly downstream of a free-running up-counter.
- Samples the counter value and detects the 3-sample sequence data==V0, then V1, then V2 on consecutive enabled samples.
- Reports per-match pulses, a sticky covered flag and a saturating match count, for use as an on-chip cover/observation point alongside formal cover properties.

Parameters:
- W, 32, width of sampled data.
- V0, 3, first sequence value.
- V1, 4, second sequence value.
- V2, 5, third sequence value.
- CNT_W, 8, width of match_count.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  sample strobe; data is a sample only when en=1.
- data  input  W  value under observation (e.g. counter x).
- clear  input  1  synchronous clear of covered, count and in-flight state.
- hit  output  1  one-cycle pulse: sequence completed on the previous enabled sample.
- covered  output  1  sticky: at least one hit since rst/clear.
- match_count  output  CNT_W  number of hits, saturating at all-ones.
- busy  output  1  an attempt is in flight (stage1 or stage2 set).

Behaviour:
- Reset (rst=1 at posedge): stage1=0, stage2=0, hit=0, covered=0, match_count=0. rst overrides all other inputs.
- Stage registers advance only on en=1 cycles. en=0 cycles are stalls: no advance, no break, hit=0.
- On en=1:
  - stage1 <= (data==V0)
  - stage2 <= stage1 & (data==V1)
  - match = stage2 & (data==V2)
- hit is registered: asserted the cycle after the V2 sample, for exactly one cycle. Latency is 1 clock from the final sample.
- Overlap: independent attempts proceed in the stage pipeline. If V0==V1==V2, a constant stream yields a hit on every enabled sample from the third onward.
- Breaking: any enabled sample that does not match the next expected value drops that attempt. A new V0 always starts a fresh attempt.
- covered <= covered | match.
- match_count increments by 1 per match and holds at 2^CNT_W-1. No wrap-around.
- clear=1 (rst=0):
  - stage1, stage2, covered, match_count and hit are set to 0 next cycle.
  - A match in the same cycle is discarded.
  - clear takes priority over en.
- busy = stage1 | stage2 (combinational from registers).
- All comparisons are full-width W-bit equality. Only data X/Z-free behaviour is specified.

Optional Feature:
- Macro: SEQ3_FIRST_HIT_STAMP_EN.
- When defined:
  - Adds a 32-bit free-running cycle counter, reset to 0 by rst, wrapping at 2^32, not affected by clear.
  - Adds output first_hit_cycle [31:0]. It captures the counter value in the cycle hit first asserts after rst/clear and holds until the next rst/clear. Its value is 0 before any hit.
- When undefined: neither the counter nor the port exists; all other behaviour is identical.

Decomposition:
- Package seq3_cover_pkg:
  - typedef for the stage vector: logic [1:0] {stage2, stage1}.
  - localparam for the cycle-stamp width (32).
  - A function for saturating increment of a CNT_W-bit count.
- One natural sub-module, seq3_sat_counter: parameterized saturating counter with inc and clr inputs, used for match_count.
- The main module holds the stage pipeline and flags.

Test Plan:
- Counter 0,1,2,… with en=1 every cycle, defaults 3/4/5 → hit pulses exactly once, the cycle after data==5. covered=1 and match_count=1 from then on; busy high during data 3 and 4.
- Same counter with V2=100, V1=3, V0=2 (stream never gives 2,3,100) → hit, covered and match_count remain 0 for 200 cycles.
- Stream 3, stall (en=0, data=77), 4, 5 → hit asserted (stall neither advances nor breaks the attempt). Stream 3, 7, 4, 5 → no hit.
- V0=V1=V2=9 with data held at 9 for 6 enabled samples → hit high on 4 consecutive cycles; match_count=4. With CNT_W=2 and 10 samples → match_count saturates at 3.
- clear asserted in the same cycle as the data==5 sample → no hit, covered=0, match_count=0 next cycle. A subsequent sequence 3,4,5 → count=1.
- rst asserted mid-attempt (after data 3,4) and released, then data 5 → no hit. With SEQ3_FIRST_HIT_STAMP_EN defined, first_hit_cycle equals the cycle index of the first hit pulse and is unchanged by a later second hit.

Source files
------------

// File: rtl/seq3_cover_monitor_pkg.sv
// Shared types and helpers for the seq3 cover monitor.
// Optional feature macro: SEQ3_FIRST_HIT_STAMP_EN (first-hit cycle stamp).
package seq3_cover_pkg;

   // Attempt pipeline: stage1 = last sample was V0, stage2 = last two were V0,V1.
   typedef struct packed {
      logic stage2;
      logic stage1;
   } stage_t;

   localparam int unsigned STAMP_W = 32;

   // Saturating +1 for a count of width w (w <= 32), zero-extended into 32 bits.
   function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned w);
      logic [31:0] max_v;
      max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
      return (cnt >= max_v) ? cnt : cnt + 32'd1;
   endfunction

endpackage

// File: rtl/seq3_cover_monitor_if.sv
// Observation bus between the sampled source and the seq3 cover monitor.
// Optional feature macro: SEQ3_FIRST_HIT_STAMP_EN adds first_hit_cycle.
interface seq3_cover_monitor_if
   import seq3_cover_pkg::*;
#(
   parameter int unsigned W     = 32,
   parameter int unsigned CNT_W = 8
);
   logic             en;
   logic [W-1:0]     data;
   logic             clear;
   logic             hit;
   logic             covered;
   logic [CNT_W-1:0] match_count;
   logic             busy;
`ifdef SEQ3_FIRST_HIT_STAMP_EN
   logic [STAMP_W-1:0] first_hit_cycle;
`endif

   modport master (
      output en, data, clear,
`ifdef SEQ3_FIRST_HIT_STAMP_EN
      input  first_hit_cycle,
`endif
      input  hit, covered, match_count, busy
   );

   modport slave (
      input  en, data, clear,
`ifdef SEQ3_FIRST_HIT_STAMP_EN
      output first_hit_cycle,
`endif
      output hit, covered, match_count, busy
   );
endinterface

// File: rtl/seq3_cover_monitor_sat_counter.sv
// Parameterized saturating up-counter with synchronous clear.
module seq3_sat_counter
   import seq3_cover_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);
   logic [CNT_W-1:0] count_q, count_d;

   // Next count: clear wins, otherwise saturating increment.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = CNT_W'(sat_inc(32'(count_q), CNT_W));
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;
endmodule

// File: rtl/seq3_cover_monitor.sv
// Cover monitor: detects data==V0,V1,V2 on consecutive enabled samples.
// Optional feature macro: SEQ3_FIRST_HIT_STAMP_EN (first-hit cycle stamp).
module seq3_cover_monitor
   import seq3_cover_pkg::*;
#(
   parameter int unsigned W     = 32,
   parameter logic [W-1:0] V0   = W'(3),
   parameter logic [W-1:0] V1   = W'(4),
   parameter logic [W-1:0] V2   = W'(5),
   parameter int unsigned CNT_W = 8
) (
   input logic                clk,
   input logic                rst,
   seq3_cover_monitor_if.slave bus
);
   stage_t stage_q, stage_d;
   logic   hit_q, hit_d;
   logic   covered_q, covered_d;
   logic   match;
   logic   count_inc;

   // Stage pipeline advance, match detection and sticky flag; clear beats en.
   always_comb begin
      stage_d   = stage_q;
      hit_d     = 1'b0;
      covered_d = covered_q;
      match     = bus.en & stage_q.stage2 & (bus.data == V2);
      if (bus.clear) begin
         stage_d   = '0;
         covered_d = 1'b0;
      end else if (bus.en) begin
         stage_d.stage1 = (bus.data == V0);
         stage_d.stage2 = stage_q.stage1 & (bus.data == V1);
         hit_d          = match;
         covered_d      = covered_q | match;
      end
   end

   // Pipeline and flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_q   <= '0;
         hit_q     <= 1'b0;
         covered_q <= 1'b0;
      end else begin
         stage_q   <= stage_d;
         hit_q     <= hit_d;
         covered_q <= covered_d;
      end
   end

   assign count_inc = match & ~bus.clear;

   seq3_sat_counter #(.CNT_W(CNT_W)) u_count (
      .clk   (clk),
      .rst   (rst),
      .clr   (bus.clear),
      .inc   (count_inc),
      .count (bus.match_count)
   );

   assign bus.hit     = hit_q;
   assign bus.covered = covered_q;
   assign bus.busy    = stage_q.stage1 | stage_q.stage2;

`ifdef SEQ3_FIRST_HIT_STAMP_EN
   logic [STAMP_W-1:0] cyc_q, cyc_d;
   logic [STAMP_W-1:0] stamp_q, stamp_d;
   logic               stamped_q, stamped_d;

   // Stamp is taken on the match cycle as cyc_q+1, i.e. the counter value
   // during the cycle hit is high, so it becomes visible together with hit.
   always_comb begin
      cyc_d     = cyc_q + 1'b1;
      stamp_d   = stamp_q;
      stamped_d = stamped_q;
      if (bus.clear) begin
         stamp_d   = '0;
         stamped_d = 1'b0;
      end else if (match && !stamped_q) begin
         stamp_d   = cyc_q + 1'b1;
         stamped_d = 1'b1;
      end
   end

   // Free-running cycle counter and first-hit stamp registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q     <= '0;
         stamp_q   <= '0;
         stamped_q <= 1'b0;
      end else begin
         cyc_q     <= cyc_d;
         stamp_q   <= stamp_d;
         stamped_q <= stamped_d;
      end
   end

   assign bus.first_hit_cycle = stamp_q;
`endif
endmodule

// File: tb/tb_seq3_cover_monitor.sv
// Scoreboard bench for seq3_cover_monitor: driver pushes hand-computed
// expectations per vector, a negedge monitor pops and compares.
module tb_seq3_cover_monitor;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        clear = 1'b0;
   logic [31:0] data = '0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   typedef struct {
      int         sel;
      logic       r;
      logic       c;
      logic       hit;
      logic       cov;
      logic [7:0] cnt;
      logic       busy;
   } exp_t;

   exp_t q[$];

   // 0: defaults 3/4/5; 1: 2/3/100; 2: 9/9/9 CNT_W=8; 3: 9/9/9 CNT_W=2
   seq3_cover_monitor_if #(.W(32), .CNT_W(8)) i0 ();
   seq3_cover_monitor_if #(.W(32), .CNT_W(8)) i1 ();
   seq3_cover_monitor_if #(.W(32), .CNT_W(8)) i2 ();
   seq3_cover_monitor_if #(.W(32), .CNT_W(2)) i3 ();

   assign i0.en = en; assign i0.data = data; assign i0.clear = clear;
   assign i1.en = en; assign i1.data = data; assign i1.clear = clear;
   assign i2.en = en; assign i2.data = data; assign i2.clear = clear;
   assign i3.en = en; assign i3.data = data; assign i3.clear = clear;

   seq3_cover_monitor dut0 (.clk(clk), .rst(rst), .bus(i0));
   seq3_cover_monitor #(.W(32), .V0(32'd2), .V1(32'd3), .V2(32'd100), .CNT_W(8))
      dut1 (.clk(clk), .rst(rst), .bus(i1));
   seq3_cover_monitor #(.W(32), .V0(32'd9), .V1(32'd9), .V2(32'd9), .CNT_W(8))
      dut2 (.clk(clk), .rst(rst), .bus(i2));
   seq3_cover_monitor #(.W(32), .V0(32'd9), .V1(32'd9), .V2(32'd9), .CNT_W(2))
      dut3 (.clk(clk), .rst(rst), .bus(i3));

   task automatic check1(input string name, input int sel, input logic [31:0] act,
                         input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, sel, $time, act, expv);
      end
   endtask

`ifdef SEQ3_FIRST_HIT_STAMP_EN
   logic [31:0] tb_cyc = '0;
   logic [31:0] stamp_exp = '0;
   logic        stamp_seen = 1'b0;
   always @(posedge clk) tb_cyc <= rst ? 32'd0 : tb_cyc + 32'd1;
`endif

   // Monitor: outputs after each sampled vector's posedge, read at negedge.
   always @(negedge clk) begin
      exp_t        e;
      logic        ah, ac, ab;
      logic [7:0]  an;
      if (q.size() > 0) begin
         e = q.pop_front();
         case (e.sel)
            0:       begin ah = i0.hit; ac = i0.covered; an = i0.match_count; ab = i0.busy; end
            1:       begin ah = i1.hit; ac = i1.covered; an = i1.match_count; ab = i1.busy; end
            2:       begin ah = i2.hit; ac = i2.covered; an = i2.match_count; ab = i2.busy; end
            default: begin ah = i3.hit; ac = i3.covered; an = {6'b0, i3.match_count}; ab = i3.busy; end
         endcase
         check1("hit", e.sel, 32'(ah), 32'(e.hit));
         check1("covered", e.sel, 32'(ac), 32'(e.cov));
         check1("match_count", e.sel, 32'(an), 32'(e.cnt));
         check1("busy", e.sel, 32'(ab), 32'(e.busy));
`ifdef SEQ3_FIRST_HIT_STAMP_EN
         if (e.r || e.c) stamp_seen = 1'b0;
         if (e.sel == 0) begin
            if (e.hit && !stamp_seen) begin
               stamp_seen = 1'b1;
               stamp_exp  = tb_cyc;
            end
            check1("first_hit_cycle", 0, i0.first_hit_cycle, stamp_seen ? stamp_exp : 32'd0);
         end
`endif
      end
   end

   task automatic step(input int sel, input logic r, input logic e, input logic c,
                       input logic [31:0] d, input logic eh, input logic ec,
                       input logic [7:0] ecnt, input logic eb);
      @(negedge clk);
      rst = r; en = e; clear = c; data = d;
      @(posedge clk);
      #1;
      q.push_back('{sel: sel, r: r, c: c, hit: eh, cov: ec, cnt: ecnt, busy: eb});
   endtask

   task automatic do_reset(input int sel);
      step(sel, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0, 1'b0);
   endtask

   initial begin
      // Reset state of every instance.
      do_reset(0); do_reset(1); do_reset(2); do_reset(3);

      // Counter 0..11: single hit after data 5, busy after 3 and 4.
      for (int d = 0; d < 12; d++)
         step(0, 1'b0, 1'b1, 1'b0, 32'(d), d == 5, d >= 5, (d >= 5) ? 8'd1 : 8'd0,
              (d == 3) || (d == 4));

      // 2/3/100 never completes on a counter; busy only after 2 and 3.
      do_reset(1);
      for (int d = 0; d < 200; d++)
         step(1, 1'b0, 1'b1, 1'b0, 32'(d), 1'b0, 1'b0, 8'd0, (d == 2) || (d == 3));

      // Stall between 3 and 4 neither advances nor breaks.
      do_reset(0);
      step(0, 0, 1, 0, 32'd3,  0, 0, 8'd0, 1);
      step(0, 0, 0, 0, 32'd77, 0, 0, 8'd0, 1);
      step(0, 0, 1, 0, 32'd4,  0, 0, 8'd0, 1);
      step(0, 0, 1, 0, 32'd5,  1, 1, 8'd1, 0);
      step(0, 0, 0, 0, 32'd5,  0, 1, 8'd1, 0);
      // 3,7,4,5 breaks the attempt.
      step(0, 0, 1, 0, 32'd3,  0, 1, 8'd1, 1);
      step(0, 0, 1, 0, 32'd7,  0, 1, 8'd1, 0);
      step(0, 0, 1, 0, 32'd4,  0, 1, 8'd1, 0);
      step(0, 0, 1, 0, 32'd5,  0, 1, 8'd1, 0);
      // Full-width compare: upper bits set must not start an attempt.
      step(0, 0, 1, 0, 32'h1000_0003, 0, 1, 8'd1, 0);

      // Constant 9 stream, 6 samples: hits from the 3rd sample on.
      do_reset(2);
      step(2, 0, 1, 0, 32'd9, 0, 0, 8'd0, 1);
      step(2, 0, 1, 0, 32'd9, 0, 0, 8'd0, 1);
      step(2, 0, 1, 0, 32'd9, 1, 1, 8'd1, 1);
      step(2, 0, 1, 0, 32'd9, 1, 1, 8'd2, 1);
      step(2, 0, 1, 0, 32'd9, 1, 1, 8'd3, 1);
      step(2, 0, 1, 0, 32'd9, 1, 1, 8'd4, 1);
      step(2, 0, 0, 0, 32'd9, 0, 1, 8'd4, 1);

      // CNT_W=2, 10 samples: count saturates at 3.
      do_reset(3);
      for (int k = 1; k <= 10; k++)
         step(3, 0, 1, 0, 32'd9, k >= 3, k >= 3,
              (k < 3) ? 8'd0 : ((k - 2 > 3) ? 8'd3 : 8'(k - 2)), 1);

      // Clear in the same cycle as the final sample discards the match.
      do_reset(0);
      step(0, 0, 1, 0, 32'd3, 0, 0, 8'd0, 1);
      step(0, 0, 1, 0, 32'd4, 0, 0, 8'd0, 1);
      step(0, 0, 1, 1, 32'd5, 0, 0, 8'd0, 0);
      step(0, 0, 1, 0, 32'd3, 0, 0, 8'd0, 1);
      step(0, 0, 1, 0, 32'd4, 0, 0, 8'd0, 1);
      step(0, 0, 1, 0, 32'd5, 1, 1, 8'd1, 0);
      // Second hit: count 2, stamp keeps the first hit.
      step(0, 0, 1, 0, 32'd3, 0, 1, 8'd1, 1);
      step(0, 0, 1, 0, 32'd4, 0, 1, 8'd1, 1);
      step(0, 0, 1, 0, 32'd5, 1, 1, 8'd2, 0);
      // Clear with en=0 drops covered and count.
      step(0, 0, 0, 1, 32'd0, 0, 0, 8'd0, 0);

      // Reset mid-attempt: following 5 does not hit.
      step(0, 0, 1, 0, 32'd3, 0, 0, 8'd0, 1);
      step(0, 0, 1, 0, 32'd4, 0, 0, 8'd0, 1);
      do_reset(0);
      step(0, 0, 1, 0, 32'd5, 0, 0, 8'd0, 0);
      step(0, 0, 0, 0, 32'd0, 0, 0, 8'd0, 0);

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
